// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame length and default bit period.
// Frame layout depends on UART_TX_PARITY_EN (even parity bit between data and stop).
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 144;
    localparam int DATA_BITS            = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        STOP   = ST_STOP,
        PARITY = ST_PARITY
    } state_t;
`else
    localparam int FRAME_BITS = 10;
    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } state_t;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO between the CPU side and the transmitter; simultaneous
// push and pop keep the count unchanged. Storage is not reset, only pointers/count.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          in,
    input  logic                          write,
    input  logic                          pop,
    output logic [DATA_BITS-1:0]          out,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic                 push;
    logic                 pull;

    assign empty = (count == '0);
    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign push  = write & ~full;
    assign pull  = pop & ~empty;
    assign out   = mem[rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pull)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pull)
                count <= count + 1'b1;
            else if (!push && pull)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter with input FIFO; frames are sent back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       write,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    state_t                     state;
    state_t                     state_next;
    logic [BW-1:0]              baud;
    logic [3:0]                 bit_cnt;
    logic [7:0]                 shifter;
    logic [7:0]                 shifter_next;
    logic                       tick;
    logic                       load;
    logic                       tx_next;
    logic [7:0]                 fifo_out;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef UART_TX_PARITY_EN
    logic                       parity;
    logic                       parity_next;
`endif

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .in    (in),
        .write (write),
        .pop   (load),
        .out   (fifo_out),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign ready = ~fifo_full;
    assign busy  = (state != IDLE) | (fifo_count != '0);
    assign tick  = (baud == BAUD_LAST);
    assign done  = (state == STOP) & tick;

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    load       = 1'b1;
                    state_next = START;
                end
            end
            START: if (tick) state_next = DATA;
            DATA: begin
                if (tick && bit_cnt == 4'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (tick) state_next = STOP;
`endif
            STOP: begin
                // Pop on the final stop clock so the next start bit follows with no gap.
                if (tick) begin
                    if (!fifo_empty) begin
                        load       = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (load)
            shifter_next = fifo_out;
        else if (state == DATA && tick)
            shifter_next = {1'b0, shifter[7:1]};
        else
            shifter_next = shifter;
`ifdef UART_TX_PARITY_EN
        parity_next = load ? ^fifo_out : parity;
`endif

        // tx is registered, so it is derived from the upcoming state and shifter.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shifter_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_next = parity_next;
`endif
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= 1'b1;
        end else begin
            state <= state_next;
            tx    <= tx_next;
            if (load || state == IDLE || tick)
                baud <= '0;
            else
                baud <= baud + 1'b1;
            if (load)
                bit_cnt <= '0;
            else if (state == DATA && tick)
                bit_cnt <= bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        shifter <= shifter_next;
`ifdef UART_TX_PARITY_EN
        parity  <= parity_next;
`endif
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: writes push expected bytes, a serial monitor
// decodes frames mid-bit and pops/compares them.
module tb_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    typedef struct {
        logic [7:0] b;
        logic       p;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       write = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;
    logic       done;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .in    (in_byte),
        .write (write),
        .ready (ready),
        .tx    (tx),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   total = 0;
    int   passed = 0;
    int   frames = 0;
    int   dones = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, want %0h", name, act, req);
    endtask

    // Monitor: detect start bit, sample each bit at its middle, compare at stop bit.
    bit         mon_active = 1'b0;
    int         mon_t = 0;
    logic [7:0] mon_sh = 8'h00;
    logic       mon_pb = 1'b0;
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (reset) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (tx === 1'b0) begin
                    mon_active = 1'b1;
                    mon_t = 0;
                end
            end else begin
                mon_t++;
                if (mon_t % CPB == CPB / 2) begin
                    k = mon_t / CPB;
                    if (k == 0) check("start_bit", tx, 0);
                    else if (k <= 8) mon_sh[k-1] = tx;
`ifdef UART_TX_PARITY_EN
                    else if (k == 9) mon_pb = tx;
`endif
                    else begin
                        check("stop_bit", tx, 1);
                        frames++;
                        mon_active = 1'b0;
                        if (exp_q.size() == 0) begin
                            total++;
                            $display("FAIL unexpected_frame: got %0h, want none", mon_sh);
                        end else begin
                            e = exp_q.pop_front();
                            check("rx_byte", mon_sh, e.b);
`ifdef UART_TX_PARITY_EN
                            check("rx_parity", mon_pb, e.p);
`endif
                        end
                    end
                end
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Drive one byte for one cycle; expectation is queued only if it will be accepted.
    task automatic put(input logic [7:0] b, input logic p, output bit accepted);
        in_byte = b;
        write = 1'b1;
        accepted = (ready === 1'b1);
        if (accepted) exp_q.push_back('{b: b, p: p});
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, input string name);
        int n = 0;
        while (busy !== 1'b0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check(name, busy, 0);
        check("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        int  d0;
        int  f0;
        int  bad;
        int  acc;
        bit  ok;
        logic [5:0] rdy;
        logic [7:0] t3 [3];
        logic [7:0] t4 [6];
        t3 = '{8'h00, 8'hFF, 8'hA5};
        t4 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_ready", ready, 1);
        check("reset_done", done, 0);
        reset = 1'b0;

        // 1: idle line
        bad = 0;
        d0 = dones;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) bad++;
        end
        check("idle_stable", bad, 0);
        check("idle_no_done", dones - d0, 0);

        // 2: single byte timing
        n = cyc;
        d0 = dones;
        put(8'h55, 1'b0, ok);
        wait_cyc(n + 1);
        check("lat_n1_tx", tx, 1);
        wait_cyc(n + 2);
        check("lat_n2_tx", tx, 0);
        wait_cyc(n + FRAME);
        check("done_not_early", done, 0);
        wait_cyc(n + 1 + FRAME);
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 1);
        wait_cyc(n + 2 + FRAME);
        check("busy_after_frame", busy, 0);
        check("done_one_cycle", done, 0);
        check("done_count_1", dones - d0, 1);
        check("scoreboard_drained", exp_q.size(), 0);

        // 3: back-to-back frames
        n = cyc;
        d0 = dones;
        for (int i = 0; i < 3; i++) put(t3[i], 1'b0, ok);
        for (int i = 1; i <= 3; i++) begin
            wait_cyc(n + 1 + i * FRAME);
            check("b2b_done", done, 1);
            if (i < 3) begin
                wait_cyc(n + 2 + i * FRAME);
                check("b2b_no_gap", tx, 0);
            end
        end
        wait_cyc(n + 2 + 3 * FRAME);
        check("b2b_busy_end", busy, 0);
        check("b2b_done_count", dones - d0, 3);

        // 4: overflow with FIFO_DEPTH=4
        d0 = dones;
        f0 = frames;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            rdy[i] = ready;
            put(t4[i], 1'b0, ok);
            if (ok) acc++;
        end
        check("ready_pattern", rdy, 6'b011111);
        check("accepted_count", acc, 5);
        wait_idle(6 * FRAME + 50, "ovf_idle");
        check("ovf_frames", frames - f0, 5);
        check("ovf_dones", dones - d0, 5);

        // 5: reset mid-frame
        n = cyc;
        put(8'h3C, 1'b0, ok);
        wait_cyc(n + 40);
        check("pre_reset_tx", tx, 0);
        d0 = dones;
        reset = 1'b1;
        @(negedge clk);
        check("abort_tx", tx, 1);
        check("abort_busy", busy, 0);
        check("abort_ready", ready, 1);
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("abort_quiet", bad, 0);
        check("abort_no_done", dones - d0, 0);
        n = cyc;
        f0 = frames;
        put(8'h81, 1'b0, ok);
        wait_cyc(n + 1 + FRAME);
        check("after_abort_done", done, 1);
        wait_idle(50, "after_abort_idle");
        check("after_abort_frames", frames - f0, 1);

`ifdef UART_TX_PARITY_EN
        // 6: parity bit
        n = cyc;
        put(8'h07, 1'b1, ok);
        wait_cyc(n + 2 + 9 * CPB + CPB / 2);
        check("parity_07", tx, 1);
        wait_cyc(n + 1 + 176);
        check("parity_frame_176", done, 1);
        wait_idle(50, "parity_idle1");
        n = cyc;
        put(8'h03, 1'b0, ok);
        wait_cyc(n + 2 + 9 * CPB + CPB / 2);
        check("parity_03", tx, 0);
        wait_idle(FRAME + 50, "parity_idle2");
`endif

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
